lookup_req_arbiter: RTL and testbench
=====================================

Name: lookup_req_arbiter

Overview:
- Shares the single MAC hash-lookup engine of the 4-port switch among the four ingress port frame processors.
- Each ingress port, after parsing a frame header (DA/SA), raises a lookup request.
- Arbiter grants round-robin, drives the engine with a req/ack handshake and returns the forwarding port map to the granted port.
- Also provides a timeout/flood fallback and lookup statistics.

Parameters:
TIMEOUT, 64, max cycles in REQ waiting for se_ack before flood fallback (>=2)
CNT_W, 16, width of statistic counters

Ports:
clk  in  1  system clock (sys_clk domain)
rstn  in  1  asynchronous active-low reset
in_req  in  4  per-port lookup request, level, held until matching res_ack
in_da  in  192  destination MAC, port n at [48n+47:48n]
in_sa  in  192  source MAC, port n at [48n+47:48n]
res_ack  out  4  one-hot, one-cycle pulse: result valid for that port
res_portmap  out  4  forwarding port map, valid with res_ack, held until next result
res_nf  out  1  DA not found / flooded, valid with res_ack
res_timeout  out  1  one-cycle pulse, coincident with res_ack on timeout
se_req  out  1  lookup request to hash engine, held until se_ack
se_da  out  48  DA to engine, stable while se_req
se_sa  out  48  SA to engine (learning), stable while se_req
se_srcport  out  4  one-hot source port, stable while se_req
se_ack  in  1  engine done, single-cycle pulse
se_result  in  4  engine port map, valid with se_ack
se_nf  in  1  engine not-found flag, valid with se_ack
busy  out  1  state != IDLE
lookup_cnt  out  CNT_W  completed lookups (incl. timeouts), saturating
timeout_cnt  out  CNT_W  timeout lookups, saturating

Behaviour:
- Reset (async, rstn=0): state=IDLE, rr_ptr=3, all outputs 0, counters 0, hold_mask=0. se_req drops immediately, including mid-REQ.
- All outputs are registered.
- FSM states IDLE, REQ, RESP.
- IDLE:
  - eff_req = in_req & ~hold_mask.
  - If eff_req != 0, grant the first set bit searching from rr_ptr+1 mod 4 upward, wrapping.
  - On that edge: latch g, se_da/se_sa = slice g, se_srcport = 1<<g, se_req=1, rr_ptr=g, timer=0, go REQ.
  - If eff_req == 0, stay in IDLE.
- REQ:
  - se_ack=1: se_req=0; res_portmap = se_result & ~se_srcport (no hairpin); res_nf=se_nf; go RESP.
  - Else if timer == TIMEOUT-1: se_req=0; res_portmap = ~se_srcport; res_nf=1; flag timeout; go RESP.
  - Else timer++.
  - se_ack is sampled only in REQ; acks in IDLE/RESP are ignored, including a late ack after timeout.
- RESP (one cycle):
  - res_ack = 1<<g; res_timeout = flag; lookup_cnt++; timeout_cnt++ if flag.
  - hold_mask = 1<<g; go IDLE.
- hold_mask applies for exactly the next IDLE cycle, then clears. Requesters must drop in_req within one cycle of res_ack; a request still high on the second cycle after res_ack is a new request.
- Latency: in_req seen at edge E0 → se_req high after E0. se_ack at edge E1 → res_ack high after E1+1. Minimum req→res_ack is 3 edges.
- Throughput: back-to-back grants are possible every 3 cycles plus engine latency.
- Simultaneous events:
  - Requests arriving during REQ/RESP wait; there is no preemption.
  - se_ack in the same cycle timer hits TIMEOUT-1: ack wins, no timeout.
- Counters saturate at all-ones.
- Deassertion of in_req[g] while granted is ignored; the lookup completes and res_ack is still issued.
- in_req, in_da and in_sa are synchronous to clk; no CDC inside this block.

Test Plan:
1. Reset, port0 req, DA=f0f1f2f3f4f5, SA=e0e1e2e3e4e5; engine acks 3 cycles later with result=4'b0110, nf=0 → se_da/se_sa match, se_srcport=0001, res_ack=0001 for one cycle, res_portmap=0110, res_nf=0, lookup_cnt=1.
2. Port1 req with DA=e0e1e2e3e4e5, SA=f0f1f2f3f4f5; engine returns 4'b1111, nf=1 → res_portmap=1101, res_nf=1, res_ack=0010.
3. All four in_req high after reset, each dropped after its ack, immediate 1-cycle acks, then all re-raised → grants in order 0,1,2,3,0,1,2,3; se_req never overlaps; res_ack pulses are one-hot.
4. Port2 req, engine never acks, TIMEOUT=64 → se_req drops after 64 cycles in REQ; res_ack=0100, res_portmap=1011, res_nf=1, res_timeout pulse, timeout_cnt=1; a se_ack injected 2 cycles later is ignored (no extra res_ack, counters unchanged).
5. rstn asserted mid-REQ for port3 → se_req, busy, res_* go 0 asynchronously; after release, ports 0 and 3 both requesting → port0 granted first.
6. Port1 holds in_req one cycle after res_ack → not regranted; holds two cycles → regranted as new lookup (lookup_cnt +2 total).

Source files
------------

// File: rtl/lookup_req_arbiter.sv
// lookup_req_arbiter: round-robin sharing of the MAC hash-lookup engine among four ingress ports,
// with req/ack engine handshake, timeout flood fallback and saturating lookup statistics.
module lookup_req_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [3:0]       in_req,
    input  logic [191:0]     in_da,
    input  logic [191:0]     in_sa,
    output logic [3:0]       res_ack,
    output logic [3:0]       res_portmap,
    output logic             res_nf,
    output logic             res_timeout,
    output logic             se_req,
    output logic [47:0]      se_da,
    output logic [47:0]      se_sa,
    output logic [3:0]       se_srcport,
    input  logic             se_ack,
    input  logic [3:0]       se_result,
    input  logic             se_nf,
    output logic             busy,
    output logic [CNT_W-1:0] lookup_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        rr_q, rr_d, gnt;
    logic [TW-1:0]     timer_q, timer_d;
    logic              flag_q, flag_d;
    logic [3:0]        hold_q, hold_d, eff;
    logic [3:0]        res_ack_q, res_ack_d, res_pm_q, res_pm_d, se_src_q, se_src_d;
    logic              res_nf_q, res_nf_d, res_to_q, res_to_d, se_req_q, se_req_d, busy_q, busy_d;
    logic [47:0]       se_da_q, se_da_d, se_sa_q, se_sa_d;
    logic [CNT_W-1:0]  lk_q, lk_d, to_q, to_d;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        timer_d   = timer_q;
        flag_d    = flag_q;
        hold_d    = '0;
        res_ack_d = '0;
        res_to_d  = 1'b0;
        res_pm_d  = res_pm_q;
        res_nf_d  = res_nf_q;
        se_req_d  = se_req_q;
        se_src_d  = se_src_q;
        se_da_d   = se_da_q;
        se_sa_d   = se_sa_q;
        lk_d      = lk_q;
        to_d      = to_q;
        // the port served last is masked for one IDLE cycle so its stale level is not regranted
        eff = in_req & ~hold_q;
        gnt = rr_q;
        for (int i = 4; i >= 1; i--)
            if (eff[rr_q + 2'(i)]) gnt = rr_q + 2'(i);
        case (state_q)
            IDLE: if (|eff) begin
                rr_d     = gnt;
                se_da_d  = in_da[48*gnt +: 48];
                se_sa_d  = in_sa[48*gnt +: 48];
                se_src_d = 4'b0001 << gnt;
                se_req_d = 1'b1;
                timer_d  = '0;
                flag_d   = 1'b0;
                state_d  = REQ;
            end
            REQ: if (se_ack) begin
                se_req_d = 1'b0;
                res_pm_d = se_result & ~se_src_q;
                res_nf_d = se_nf;
                state_d  = RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
                se_req_d = 1'b0;
                res_pm_d = ~se_src_q;
                res_nf_d = 1'b1;
                flag_d   = 1'b1;
                state_d  = RESP;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            RESP: begin
                res_ack_d = se_src_q;
                res_to_d  = flag_q;
                lk_d      = &lk_q ? lk_q : lk_q + 1'b1;
                to_d      = (flag_q && !(&to_q)) ? to_q + 1'b1 : to_q;
                hold_d    = se_src_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rr_q      <= 2'd3;
            timer_q   <= '0;
            flag_q    <= 1'b0;
            hold_q    <= '0;
            res_ack_q <= '0;
            res_pm_q  <= '0;
            res_nf_q  <= 1'b0;
            res_to_q  <= 1'b0;
            se_req_q  <= 1'b0;
            se_src_q  <= '0;
            se_da_q   <= '0;
            se_sa_q   <= '0;
            busy_q    <= 1'b0;
            lk_q      <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            timer_q   <= timer_d;
            flag_q    <= flag_d;
            hold_q    <= hold_d;
            res_ack_q <= res_ack_d;
            res_pm_q  <= res_pm_d;
            res_nf_q  <= res_nf_d;
            res_to_q  <= res_to_d;
            se_req_q  <= se_req_d;
            se_src_q  <= se_src_d;
            se_da_q   <= se_da_d;
            se_sa_q   <= se_sa_d;
            busy_q    <= busy_d;
            lk_q      <= lk_d;
            to_q      <= to_d;
        end
    end

    assign res_ack     = res_ack_q;
    assign res_portmap = res_pm_q;
    assign res_nf      = res_nf_q;
    assign res_timeout = res_to_q;
    assign se_req      = se_req_q;
    assign se_da       = se_da_q;
    assign se_sa       = se_sa_q;
    assign se_srcport  = se_src_q;
    assign busy        = busy_q;
    assign lookup_cnt  = lk_q;
    assign timeout_cnt = to_q;
endmodule

// File: tb/tb_lookup_req_arbiter.sv
// tb_lookup_req_arbiter: vector table, directed corner sequences and a randomized
// transaction-level reference model for lookup_req_arbiter.
module tb_lookup_req_arbiter;
    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   in_req = '0;
    logic [191:0] in_da = '0, in_sa = '0;
    logic [3:0]   res_ack, res_portmap, se_srcport;
    logic         res_nf, res_timeout, se_req, busy;
    logic [47:0]  se_da, se_sa;
    logic         se_ack = 1'b0;
    logic [3:0]   se_result = '0;
    logic         se_nf = 1'b0;
    logic [15:0]  lookup_cnt, timeout_cnt;

    int n_vec = 0, n_err = 0;

    lookup_req_arbiter #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .in_req(in_req), .in_da(in_da), .in_sa(in_sa),
        .res_ack(res_ack), .res_portmap(res_portmap), .res_nf(res_nf), .res_timeout(res_timeout),
        .se_req(se_req), .se_da(se_da), .se_sa(se_sa), .se_srcport(se_srcport),
        .se_ack(se_ack), .se_result(se_result), .se_nf(se_nf), .busy(busy),
        .lookup_cnt(lookup_cnt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic        ack;
        logic [3:0]  res;
        logic        nf;
        logic        x_sereq;
        logic        x_busy;
        logic [3:0]  x_rack;
        logic [3:0]  x_pm;
        logic        x_nf;
        logic [15:0] x_lk;
        logic [47:0] x_da;
        logic [47:0] x_sa;
    } vec_t;

    localparam logic [47:0] MAC_F = 48'hf0f1f2f3f4f5;
    localparam logic [47:0] MAC_E = 48'he0e1e2e3e4e5;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_req = '0;
        se_ack = 1'b0;
        rstn   = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    function automatic int rr_pick(input int rr, input logic [3:0] eff);
        for (int i = 1; i <= 4; i++)
            if (eff[(rr + i) % 4]) return (rr + i) % 4;
        return -1;
    endfunction

    vec_t tbl[10];

    initial begin
        int got, n, m_rr, m_lk, m_to, g, k, exp_end, txn;
        logic [3:0] req, hold, eff, pm, r;
        logic nf, extra;
        logic [47:0] da[4], sa[4];

        tbl = '{
            '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'd0, MAC_F, MAC_E},
            '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'd0, MAC_F, MAC_E},
            '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 16'd0, MAC_F, MAC_E},
            '{4'b0001, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0110, 1'b0, 16'd0, 48'h0, 48'h0},
            '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0110, 1'b0, 16'd1, 48'h0, 48'h0},
            '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0, 16'd1, 48'h0, 48'h0},
            '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0110, 1'b0, 16'd1, MAC_E, MAC_F},
            '{4'b0010, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b1101, 1'b1, 16'd1, 48'h0, 48'h0},
            '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b1101, 1'b1, 16'd2, 48'h0, 48'h0},
            '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1101, 1'b1, 16'd2, 48'h0, 48'h0}
        };

        // reset state
        do_reset();
        chk("reset ctl", {se_req, busy, res_ack, res_portmap, res_nf, res_timeout, se_srcport},
            64'h0);
        chk("reset cnt", {lookup_cnt, timeout_cnt}, 64'h0);
        chk("reset mac", {se_da, se_sa}, 64'h0);

        // tests 1 and 2 as a per-cycle vector table
        in_da = {96'h0, MAC_E, MAC_F};
        in_sa = {96'h0, MAC_F, MAC_E};
        for (int i = 0; i < 10; i++) begin
            in_req = tbl[i].req; se_ack = tbl[i].ack; se_result = tbl[i].res; se_nf = tbl[i].nf;
            tick();
            se_ack = 1'b0;
            chk($sformatf("vec%0d", i), {se_req, busy, res_ack, res_portmap, res_nf, lookup_cnt},
                {tbl[i].x_sereq, tbl[i].x_busy, tbl[i].x_rack, tbl[i].x_pm, tbl[i].x_nf, tbl[i].x_lk});
            if (tbl[i].x_sereq)
                chk($sformatf("vec%0d da/sa/src", i), {se_da[15:0], se_sa[15:0], se_srcport},
                    {tbl[i].x_da[15:0], tbl[i].x_sa[15:0], (i < 3) ? 4'b0001 : 4'b0010});
        end

        // test 3: all four requesting, immediate acks, order 0..3 twice
        do_reset();
        in_req = 4'b1111;
        got = 0;
        for (int c = 0; c < 200 && got < 8; c++) begin
            se_ack = se_req;
            se_result = 4'($urandom);
            tick();
            se_ack = 1'b0;
            if (!$onehot0(res_ack)) chk("t3 res_ack onehot", res_ack, 4'b0);
            if (res_ack != 0) begin
                chk($sformatf("t3 grant %0d", got), res_ack, 4'b0001 << (got % 4));
                got++;
                in_req = in_req & ~res_ack;
                if (got == 4 && in_req == 0) in_req = 4'b1111;
            end
        end
        chk("t3 completed", got, 8);
        chk("t3 lookup_cnt", lookup_cnt, 8);

        // test 4: engine never acks on port 2
        in_req = 4'b0100;
        tick();
        chk("t4 grant", {se_req, se_srcport}, {1'b1, 4'b0100});
        n = 0;
        while (se_req && n < 200) begin tick(); n++; end
        chk("t4 se_req cycles", n, 64);
        chk("t4 flood map", {res_portmap, res_nf, res_ack}, {4'b1011, 1'b1, 4'b0000});
        tick();
        chk("t4 timeout resp", {res_ack, res_timeout, timeout_cnt, lookup_cnt},
            {4'b0100, 1'b1, 16'd1, 16'd9});
        in_req = '0;
        tick();
        se_ack = 1'b1;
        tick();
        se_ack = 1'b0;
        extra = 1'b0;
        repeat (3) begin tick(); extra |= (res_ack != 0) | busy | se_req; end
        chk("t4 late ack ignored", {extra, lookup_cnt, timeout_cnt}, {1'b0, 16'd9, 16'd1});

        // test 5: async reset mid-REQ
        in_req = 4'b1000;
        tick();
        chk("t5 grant p3", {se_req, se_srcport}, {1'b1, 4'b1000});
        tick();
        #2 rstn = 1'b0;
        #1 chk("t5 async clear", {se_req, busy, res_ack, res_portmap, res_nf, lookup_cnt},
               64'h0);
        in_req = 4'b1001;
        @(negedge clk) rstn = 1'b1;
        tick();
        chk("t5 p0 first", {se_req, se_srcport}, {1'b1, 4'b0001});
        in_req = '0;
        se_ack = 1'b1;
        tick();
        se_ack = 1'b0;
        tick();

        // test 6: hold mask covers one cycle only
        do_reset();
        in_req = 4'b0010;
        tick();
        se_ack = 1'b1; tick(); se_ack = 1'b0; tick();
        chk("t6a res_ack", res_ack, 4'b0010);
        tick();
        chk("t6a no regrant", se_req, 1'b0);
        in_req = '0;
        tick();
        in_req = 4'b0010;
        tick();
        se_ack = 1'b1; tick(); se_ack = 1'b0; tick();
        chk("t6b res_ack", res_ack, 4'b0010);
        tick();
        chk("t6b masked cycle", se_req, 1'b0);
        tick();
        chk("t6b regrant", {se_req, se_srcport}, {1'b1, 4'b0010});
        in_req = '0;
        se_ack = 1'b1; tick(); se_ack = 1'b0; tick();
        chk("t6 lookup_cnt", {res_ack, lookup_cnt}, {4'b0010, 16'd3});

        // randomized transactions against a transaction-level model
        do_reset();
        m_rr = 3; m_lk = 0; m_to = 0;
        req = '0; hold = '0; txn = 0;
        for (int it = 0; it < 400 && txn < 40; it++) begin
            for (int p = 0; p < 4; p++)
                if (!req[p] && $urandom_range(0, 1) == 1) begin
                    req[p] = 1'b1;
                    da[p] = {16'($urandom), 32'($urandom)};
                    sa[p] = {16'($urandom), 32'($urandom)};
                    in_da[48*p +: 48] = da[p];
                    in_sa[48*p +: 48] = sa[p];
                end
            in_req = req;
            eff = req & ~hold;
            tick();
            hold = '0;
            if (eff == 0) begin
                chk("rnd idle", se_req, 1'b0);
                continue;
            end
            g = rr_pick(m_rr, eff);
            m_rr = g;
            chk("rnd grant", {se_req, se_srcport}, {1'b1, 4'b0001 << g});
            chk("rnd mac", {se_da[31:0], se_sa[31:0]}, {da[g][31:0], sa[g][31:0]});
            n = $urandom_range(0, 9);
            k = (n < 6) ? n + 1 : (n == 6) ? 63 : (n == 7) ? 64 : 65;
            exp_end = (k <= 64) ? k : 64;
            pm = ~(4'b0001 << g);
            nf = 1'b1;
            for (int e = 1; e <= 70; e++) begin
                r = 4'($urandom);
                se_result = r;
                se_nf = 1'($urandom);
                se_ack = (e == k);
                if (e == k && k <= 64) begin pm = r & ~(4'b0001 << g); nf = se_nf; end
                for (int p = 0; p < 4; p++)
                    if (!req[p] && $urandom_range(0, 7) == 0) begin
                        req[p] = 1'b1;
                        da[p] = {16'($urandom), 32'($urandom)};
                        sa[p] = {16'($urandom), 32'($urandom)};
                        in_da[48*p +: 48] = da[p];
                        in_sa[48*p +: 48] = sa[p];
                    end
                in_req = req;
                tick();
                se_ack = 1'b0;
                if (e < exp_end) chk("rnd se_req held", {se_req, res_ack}, {1'b1, 4'b0});
                if (e == exp_end)
                    chk("rnd result", {se_req, res_portmap, res_nf}, {1'b0, pm, nf});
                if (e == exp_end + 1) begin
                    m_lk++;
                    if (k > 64) m_to++;
                    chk("rnd res_ack", {res_ack, res_timeout}, {4'b0001 << g, k > 64});
                    chk("rnd counters", {lookup_cnt, timeout_cnt}, {16'(m_lk), 16'(m_to)});
                    break;
                end
            end
            req[g] = 1'b0;
            in_req = req;
            hold = 4'b0001 << g;
            txn++;
        end
        chk("rnd transactions", txn, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
